// File: rtl/panel_pkg.sv
// Shared types, encodings and helpers for the front-panel command sequencer.
package panel_pkg;

    typedef enum logic [2:0] {
        M_CLEAR,
        M_WRITE,
        M_READ,
        E_ADDR_LO,
        E_ADDR_HI,
        E_DATA,
        ISSUE,
        WAIT
    } state_t;

    typedef enum logic [1:0] {
        OP_CLEAR = 2'b00,
        OP_READ  = 2'b01,
        OP_WRITE = 2'b10
    } cmd_op_t;

    localparam logic [1:0] MODE_BUSY     = 2'b11;
    localparam logic [1:0] STAGE_MODE    = 2'd0;
    localparam logic [1:0] STAGE_ADDR_LO = 2'd1;
    localparam logic [1:0] STAGE_ADDR_HI = 2'd2;
    localparam logic [1:0] STAGE_DATA    = 2'd3;

    // Edge vector layout: {sw[4:0], key1, key0}
    localparam int unsigned EDGE_W = 7;

    function automatic logic [15:0] inc_digit(input logic [15:0] v, input int unsigned idx);
        logic [15:0] r;
        r = v;
        for (int unsigned i = 0; i < 4; i++) begin
            if (i == idx) r[4*i +: 4] = v[4*i +: 4] + 4'd1;
        end
        return r;
    endfunction

    function automatic state_t mode_state(input cmd_op_t op);
        case (op)
            OP_WRITE: return M_WRITE;
            OP_READ:  return M_READ;
            default:  return M_CLEAR;
        endcase
    endfunction

endpackage

// File: rtl/panel_edge_sync.sv
// Multi-flop synchronizer followed by a registered rising-edge detector.
module panel_edge_sync #(
    parameter int unsigned W           = 1,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] async_in,
    output logic [W-1:0] rise
);

    logic [SYNC_STAGES-1:0][W-1:0] sync_q, sync_d;
    logic [W-1:0]                  prev_q, prev_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], async_in};
        prev_d = sync_q[SYNC_STAGES-1];
        rise   = sync_q[SYNC_STAGES-1] & ~prev_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
            prev_q <= '0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

endmodule

// File: rtl/panel_cmd_sequencer.sv
// Front-panel command builder: key/switch edges assemble clear/write/read commands,
// handshake them to the memory controller and show the result on the hex display.
module panel_cmd_sequencer
    import panel_pkg::*;
#(
    parameter int unsigned ADDR_W      = 25,
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              key0,
    input  logic              key1,
    input  logic [4:0]        sw,
    input  logic              cmdReady,
    input  logic              memDone,
    input  logic [DATA_W-1:0] memReadData,
    output logic              cmdValid,
    output logic [1:0]        cmdOp,
    output logic [ADDR_W-1:0] memoryAddress,
    output logic [DATA_W-1:0] ioDataOut,
    output logic [1:0]        modeOutput,
    output logic [1:0]        stageLevel,
    output logic [15:0]       displayData,
    output logic              ioDone,
    output logic              ioError
);

    localparam int unsigned HI_W      = ADDR_W - 16;
    localparam logic [15:0] HI_MASK   = 16'((32'd1 << HI_W) - 32'd1);
    localparam logic [15:0] DATA_MASK = 16'((32'd1 << DATA_W) - 32'd1);
    localparam logic [31:0] TMO_LAST  = (TIMEOUT_CYC == 0) ? 32'd0 : 32'(TIMEOUT_CYC) - 32'd1;

    logic [EDGE_W-1:0] rise;
    logic              key0_rise, key1_rise, clr_rise, busy;
    logic [3:0]        inc_rise;

    state_t            state_q, state_d;
    cmd_op_t           op_q, op_d;
    logic [15:0]       addr_lo_q, addr_lo_d, addr_hi_q, addr_hi_d;
    logic [15:0]       data_q, data_d, rd_q, rd_d;
    logic [31:0]       tmo_q, tmo_d;

    logic              cmd_valid_q, cmd_valid_d, io_done_q, io_done_d, io_error_q, io_error_d;
    logic [1:0]        cmd_op_q, cmd_op_d, mode_q, mode_d, stage_q, stage_d;
    logic [ADDR_W-1:0] addr_out_q, addr_out_d;
    logic [DATA_W-1:0] data_out_q, data_out_d;
    logic [15:0]       disp_q, disp_d;

    panel_edge_sync #(
        .W           (EDGE_W),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_edge_sync (
        .clk      (clk),
        .reset    (reset),
        .async_in ({sw, key1, key0}),
        .rise     (rise)
    );

    always_comb begin
        key0_rise = rise[0];
        key1_rise = rise[1];
        inc_rise  = rise[5:2];
        clr_rise  = rise[6];
    end

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        addr_lo_d  = addr_lo_q;
        addr_hi_d  = addr_hi_q;
        data_d     = data_q;
        rd_d       = rd_q;
        tmo_d      = '0;
        io_done_d  = 1'b0;
        io_error_d = io_error_q;
        busy       = (state_q == ISSUE) || (state_q == WAIT);

        if (!busy && key1_rise) io_error_d = 1'b0;

        // Masking after the nibble increment makes partial top digits wrap at their width
        for (int unsigned i = 0; i < 4; i++) begin
            if (inc_rise[i]) begin
                case (state_q)
                    E_ADDR_LO: addr_lo_d = inc_digit(addr_lo_d, i);
                    E_ADDR_HI: addr_hi_d = inc_digit(addr_hi_d, i) & HI_MASK;
                    E_DATA:    data_d    = inc_digit(data_d, i) & DATA_MASK;
                    default:   ;
                endcase
            end
        end

        if (!busy && clr_rise) begin
            addr_lo_d = '0;
            addr_hi_d = '0;
            data_d    = '0;
        end

        case (state_q)
            M_CLEAR, M_WRITE, M_READ: begin
                if (key0_rise) begin
                    case (state_q)
                        M_CLEAR: begin state_d = M_WRITE; op_d = OP_WRITE; end
                        M_WRITE: begin state_d = M_READ;  op_d = OP_READ;  end
                        default: begin state_d = M_CLEAR; op_d = OP_CLEAR; end
                    endcase
                end else if (key1_rise) begin
                    state_d = (state_q == M_CLEAR) ? ISSUE : E_ADDR_LO;
                end
            end
            E_ADDR_LO: begin
                if (key0_rise)      state_d = mode_state(op_q);
                else if (key1_rise) state_d = E_ADDR_HI;
            end
            E_ADDR_HI: begin
                if (key0_rise)      state_d = mode_state(op_q);
                else if (key1_rise) state_d = (op_q == OP_WRITE) ? E_DATA : ISSUE;
            end
            E_DATA: begin
                if (key0_rise)      state_d = mode_state(op_q);
                else if (key1_rise) state_d = ISSUE;
            end
            ISSUE: begin
                if (cmd_valid_q && cmdReady) state_d = WAIT;
            end
            WAIT: begin
                if (memDone) begin
                    io_done_d = 1'b1;
                    if (op_q == OP_READ) rd_d = 16'(memReadData);
                    state_d = mode_state(op_q);
                end else if (TIMEOUT_CYC != 0 && tmo_q == TMO_LAST) begin
                    io_error_d = 1'b1;
                    state_d    = mode_state(op_q);
                end else begin
                    tmo_d = tmo_q + 32'd1;
                end
            end
            default: state_d = M_CLEAR;
        endcase

        // Output registers load from next-state values so they align with state_q
        cmd_valid_d = (state_d == ISSUE);
        cmd_op_d    = op_d;
        addr_out_d  = {addr_hi_d[HI_W-1:0], addr_lo_d};
        data_out_d  = data_d[DATA_W-1:0];
        mode_d      = (state_d == ISSUE || state_d == WAIT) ? MODE_BUSY : op_d;
        case (state_d)
            E_ADDR_LO: begin stage_d = STAGE_ADDR_LO; disp_d = addr_lo_d; end
            E_ADDR_HI: begin stage_d = STAGE_ADDR_HI; disp_d = addr_hi_d; end
            E_DATA:    begin stage_d = STAGE_DATA;    disp_d = data_d;    end
            default:   begin stage_d = STAGE_MODE;    disp_d = rd_d;      end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= M_CLEAR;
            op_q        <= OP_CLEAR;
            addr_lo_q   <= '0;
            addr_hi_q   <= '0;
            data_q      <= '0;
            rd_q        <= '0;
            tmo_q       <= '0;
            cmd_valid_q <= 1'b0;
            cmd_op_q    <= OP_CLEAR;
            addr_out_q  <= '0;
            data_out_q  <= '0;
            mode_q      <= OP_CLEAR;
            stage_q     <= STAGE_MODE;
            disp_q      <= '0;
            io_done_q   <= 1'b0;
            io_error_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            addr_lo_q   <= addr_lo_d;
            addr_hi_q   <= addr_hi_d;
            data_q      <= data_d;
            rd_q        <= rd_d;
            tmo_q       <= tmo_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_op_q    <= cmd_op_d;
            addr_out_q  <= addr_out_d;
            data_out_q  <= data_out_d;
            mode_q      <= mode_d;
            stage_q     <= stage_d;
            disp_q      <= disp_d;
            io_done_q   <= io_done_d;
            io_error_q  <= io_error_d;
        end
    end

    always_comb begin
        cmdValid      = cmd_valid_q;
        cmdOp         = cmd_op_q;
        memoryAddress = addr_out_q;
        ioDataOut     = data_out_q;
        modeOutput    = mode_q;
        stageLevel    = stage_q;
        displayData   = disp_q;
        ioDone        = io_done_q;
        ioError       = io_error_q;
    end

endmodule

// File: tb/tb_panel_cmd_sequencer.sv
// Scenario bench for panel_cmd_sequencer: expected commands are queued as keys are
// pressed and compared when the sequencer raises cmdValid.
module tb_panel_cmd_sequencer;
    import panel_pkg::*;

    localparam int unsigned ADDR_W = 25;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned TMO    = 40;

    localparam logic [6:0] K0  = 7'b0000001;
    localparam logic [6:0] K1  = 7'b0000010;
    localparam logic [6:0] SW0 = 7'b0000100;
    localparam logic [6:0] SW1 = 7'b0001000;
    localparam logic [6:0] SW2 = 7'b0010000;
    localparam logic [6:0] SW3 = 7'b0100000;
    localparam logic [6:0] SW4 = 7'b1000000;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [6:0]        pins = '0;
    logic              cmdReady = 1'b0;
    logic              memDone = 1'b0;
    logic [DATA_W-1:0] memReadData = '0;
    logic              cmdValid, ioDone, ioError;
    logic [1:0]        cmdOp, modeOutput, stageLevel;
    logic [ADDR_W-1:0] memoryAddress;
    logic [DATA_W-1:0] ioDataOut;
    logic [15:0]       displayData;

    int vec_cnt  = 0;
    int miss_cnt = 0;

    typedef struct {
        logic [1:0]  op;
        logic [24:0] addr;
        logic [15:0] data;
        bit          chk_addr;
        bit          chk_data;
    } exp_t;
    exp_t exp_q[$];

    panel_cmd_sequencer #(
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .SYNC_STAGES (2),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .key0          (pins[0]),
        .key1          (pins[1]),
        .sw            (pins[6:2]),
        .cmdReady      (cmdReady),
        .memDone       (memDone),
        .memReadData   (memReadData),
        .cmdValid      (cmdValid),
        .cmdOp         (cmdOp),
        .memoryAddress (memoryAddress),
        .ioDataOut     (ioDataOut),
        .modeOutput    (modeOutput),
        .stageLevel    (stageLevel),
        .displayData   (displayData),
        .ioDone        (ioDone),
        .ioError       (ioError)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 500us");
        $fatal(1);
    end

    task automatic press(input logic [6:0] m);
        @(negedge clk) pins = m;
        repeat (4) @(negedge clk);
        pins = '0;
        repeat (4) @(negedge clk);
    endtask

    task automatic press_n(input logic [6:0] m, input int n);
        for (int i = 0; i < n; i++) press(m);
    endtask

    task automatic enter_value(input logic [15:0] v, input int nd);
        for (int i = 0; i < nd; i++) press_n(SW0 << i, int'(v[4*i +: 4]));
    endtask

    task automatic run_cmd(input int ready_delay, input bit respond,
                           input logic [15:0] rdata, input logic [1:0] ret_mode);
        exp_t e;
        int   waited;
        waited = 0;
        while (cmdValid !== 1'b1 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        vec_cnt++;
        if (cmdValid !== 1'b1) begin
            miss_cnt++;
            $display("FAIL cmd_valid_wait: cmdValid=%b, required 1 within 50 cycles", cmdValid);
            return;
        end
        vec_cnt++;
        if (exp_q.size() == 0) begin
            miss_cnt++;
            $display("FAIL cmd_unexpected: got op %b, required no command", cmdOp);
            return;
        end
        e = exp_q.pop_front();
        for (int i = 0; i <= ready_delay; i++) begin
            if (i > 0) @(negedge clk);
            vec_cnt++;
            if (cmdValid !== 1'b1 || cmdOp !== e.op || modeOutput !== MODE_BUSY
                || (e.chk_addr && memoryAddress !== e.addr)
                || (e.chk_data && ioDataOut !== e.data)) begin
                miss_cnt++;
                $display("FAIL cmd_hold[%0d]: valid=%b op=%b mode=%b addr=%h data=%h, required 1 %b 11 %h %h",
                         i, cmdValid, cmdOp, modeOutput, memoryAddress, ioDataOut, e.op, e.addr, e.data);
            end
        end
        cmdReady = 1'b1;
        @(negedge clk);
        cmdReady = 1'b0;
        vec_cnt++;
        if (cmdValid !== 1'b0) begin
            miss_cnt++;
            $display("FAIL cmd_drop: cmdValid=%b after handshake, required 0", cmdValid);
        end
        if (!respond) return;
        repeat (2) @(negedge clk);
        vec_cnt++;
        if (ioDone !== 1'b0 || modeOutput !== MODE_BUSY) begin
            miss_cnt++;
            $display("FAIL wait_busy: ioDone=%b mode=%b, required 0 11", ioDone, modeOutput);
        end
        memDone = 1'b1;
        memReadData = rdata;
        @(negedge clk);
        memDone = 1'b0;
        memReadData = '0;
        vec_cnt++;
        if (ioDone !== 1'b1 || modeOutput !== ret_mode) begin
            miss_cnt++;
            $display("FAIL done_pulse: ioDone=%b mode=%b, required 1 %b", ioDone, modeOutput, ret_mode);
        end
        @(negedge clk);
        vec_cnt++;
        if (ioDone !== 1'b0) begin
            miss_cnt++;
            $display("FAIL done_width: ioDone=%b one cycle later, required 0", ioDone);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        vec_cnt++;
        if (cmdValid !== 1'b0 || ioDone !== 1'b0 || ioError !== 1'b0 || displayData !== 16'h0
            || modeOutput !== 2'b00 || stageLevel !== 2'd0 || memoryAddress !== 25'h0) begin
            miss_cnt++;
            $display("FAIL reset_state: valid=%b done=%b err=%b disp=%h mode=%b stage=%0d addr=%h, required all zero",
                     cmdValid, ioDone, ioError, displayData, modeOutput, stageLevel, memoryAddress);
        end
        reset = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_addr_entry();
        press(K0);
        vec_cnt++;
        if (modeOutput !== 2'b10 || stageLevel !== 2'd0) begin
            miss_cnt++;
            $display("FAIL mode_write: mode=%b stage=%0d, required 10 0", modeOutput, stageLevel);
        end
        press(K1);
        press_n(SW0, 3);
        press(SW3);
        vec_cnt++;
        if (stageLevel !== 2'd1 || displayData !== 16'h1003 || memoryAddress[15:0] !== 16'h1003) begin
            miss_cnt++;
            $display("FAIL addr_lo_entry: stage=%0d disp=%h addr=%h, required 1 1003 1003",
                     stageLevel, displayData, memoryAddress[15:0]);
        end
        press(K1);
        vec_cnt++;
        if (stageLevel !== 2'd2 || memoryAddress !== 25'h0001003 || displayData !== 16'h0000) begin
            miss_cnt++;
            $display("FAIL addr_hi_stage: stage=%0d addr=%h disp=%h, required 2 0001003 0000",
                     stageLevel, memoryAddress, displayData);
        end
    endtask

    task automatic test_write_cmd();
        press(K0);
        vec_cnt++;
        if (modeOutput !== 2'b10 || stageLevel !== 2'd0) begin
            miss_cnt++;
            $display("FAIL abort_hi: mode=%b stage=%0d, required 10 0", modeOutput, stageLevel);
        end
        press(K1);
        press(SW4);
        enter_value(16'h2345, 4);
        press(K1);
        enter_value(16'h0001, 1);
        press(K1);
        enter_value(16'hBEEF, 4);
        vec_cnt++;
        if (stageLevel !== 2'd3 || displayData !== 16'hBEEF || memoryAddress !== 25'h0012345) begin
            miss_cnt++;
            $display("FAIL data_entry: stage=%0d disp=%h addr=%h, required 3 beef 0012345",
                     stageLevel, displayData, memoryAddress);
        end
        exp_q.push_back('{op: 2'b10, addr: 25'h0012345, data: 16'hBEEF, chk_addr: 1'b1, chk_data: 1'b1});
        press(K1);
        run_cmd(5, 1'b1, 16'h1234, 2'b10);
        vec_cnt++;
        if (displayData !== 16'h0000 || stageLevel !== 2'd0) begin
            miss_cnt++;
            $display("FAIL write_no_capture: disp=%h stage=%0d, required 0000 0", displayData, stageLevel);
        end
    endtask

    task automatic test_read_cmd();
        press(K0);
        press(K1);
        vec_cnt++;
        if (modeOutput !== 2'b01 || stageLevel !== 2'd1 || memoryAddress !== 25'h0012345) begin
            miss_cnt++;
            $display("FAIL read_retain: mode=%b stage=%0d addr=%h, required 01 1 0012345",
                     modeOutput, stageLevel, memoryAddress);
        end
        press(K1);
        exp_q.push_back('{op: 2'b01, addr: 25'h0012345, data: 16'h0, chk_addr: 1'b1, chk_data: 1'b0});
        press(K1);
        run_cmd(0, 1'b1, 16'hBEEF, 2'b01);
        vec_cnt++;
        if (displayData !== 16'hBEEF || modeOutput !== 2'b01 || stageLevel !== 2'd0) begin
            miss_cnt++;
            $display("FAIL read_display: disp=%h mode=%b stage=%0d, required beef 01 0",
                     displayData, modeOutput, stageLevel);
        end
    endtask

    task automatic test_digits();
        press(K0);
        press(K0);
        press(K1);
        press(SW4);
        vec_cnt++;
        if (memoryAddress !== 25'h0 || displayData !== 16'h0) begin
            miss_cnt++;
            $display("FAIL clear_all: addr=%h disp=%h, required 0 0", memoryAddress, displayData);
        end
        press_n(SW0, 17);
        vec_cnt++;
        if (memoryAddress[15:0] !== 16'h0001 || displayData !== 16'h0001) begin
            miss_cnt++;
            $display("FAIL digit_wrap: addr=%h disp=%h, required 0001 0001", memoryAddress[15:0], displayData);
        end
        press(K1);
        press_n(SW2, 3);
        vec_cnt++;
        if (memoryAddress !== 25'h1000001 || displayData !== 16'h0100) begin
            miss_cnt++;
            $display("FAIL top_digit: addr=%h disp=%h, required 1000001 0100", memoryAddress, displayData);
        end
        press(SW3);
        vec_cnt++;
        if (memoryAddress !== 25'h1000001 || displayData !== 16'h0100) begin
            miss_cnt++;
            $display("FAIL unused_digit: addr=%h disp=%h, required 1000001 0100", memoryAddress, displayData);
        end
        press(SW4 | SW1);
        vec_cnt++;
        if (memoryAddress !== 25'h0 || displayData !== 16'h0) begin
            miss_cnt++;
            $display("FAIL clear_wins: addr=%h disp=%h, required 0 0", memoryAddress, displayData);
        end
    endtask

    task automatic test_timeout();
        int  rise_at;
        bit  saw_done;
        press(K1);
        vec_cnt++;
        if (stageLevel !== 2'd3 || displayData !== 16'h0000) begin
            miss_cnt++;
            $display("FAIL data_cleared: stage=%0d disp=%h, required 3 0000", stageLevel, displayData);
        end
        exp_q.push_back('{op: 2'b10, addr: 25'h0, data: 16'h0, chk_addr: 1'b1, chk_data: 1'b1});
        press(K1);
        run_cmd(1, 1'b0, 16'h0, 2'b10);
        rise_at  = -1;
        saw_done = 1'b0;
        for (int i = 1; i <= int'(TMO) + 10; i++) begin
            @(negedge clk);
            if (ioDone === 1'b1) saw_done = 1'b1;
            if (ioError === 1'b1 && rise_at < 0) rise_at = i;
        end
        vec_cnt++;
        if (rise_at != int'(TMO) || saw_done) begin
            miss_cnt++;
            $display("FAIL timeout: ioError rose at cycle %0d, ioDone seen %0d, required %0d and 0",
                     rise_at, saw_done, TMO);
        end
        vec_cnt++;
        if (modeOutput !== 2'b10 || cmdValid !== 1'b0) begin
            miss_cnt++;
            $display("FAIL timeout_return: mode=%b valid=%b, required 10 0", modeOutput, cmdValid);
        end
        memDone = 1'b1;
        @(negedge clk);
        memDone = 1'b0;
        vec_cnt++;
        if (ioDone !== 1'b0 || ioError !== 1'b1) begin
            miss_cnt++;
            $display("FAIL stray_done: ioDone=%b ioError=%b, required 0 1", ioDone, ioError);
        end
        press(K1);
        vec_cnt++;
        if (ioError !== 1'b0 || stageLevel !== 2'd1) begin
            miss_cnt++;
            $display("FAIL error_clear: ioError=%b stage=%0d, required 0 1", ioError, stageLevel);
        end
    endtask

    task automatic test_abort_and_reset();
        press_n(K1, 2);
        vec_cnt++;
        if (stageLevel !== 2'd3) begin
            miss_cnt++;
            $display("FAIL reach_data: stage=%0d, required 3", stageLevel);
        end
        press(K0 | K1);
        vec_cnt++;
        if (modeOutput !== 2'b10 || stageLevel !== 2'd0 || cmdValid !== 1'b0) begin
            miss_cnt++;
            $display("FAIL key0_wins: mode=%b stage=%0d valid=%b, required 10 0 0",
                     modeOutput, stageLevel, cmdValid);
        end
        press_n(K1, 4);
        vec_cnt++;
        if (cmdValid !== 1'b1 || cmdOp !== 2'b10) begin
            miss_cnt++;
            $display("FAIL issue_before_reset: valid=%b op=%b, required 1 10", cmdValid, cmdOp);
        end
        reset = 1'b1;
        @(negedge clk);
        vec_cnt++;
        if (cmdValid !== 1'b0 || modeOutput !== 2'b00 || stageLevel !== 2'd0 || displayData !== 16'h0) begin
            miss_cnt++;
            $display("FAIL reset_in_issue: valid=%b mode=%b stage=%0d disp=%h, required 0 00 0 0000",
                     cmdValid, modeOutput, stageLevel, displayData);
        end
        reset = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_clear_cmd();
        exp_q.push_back('{op: 2'b00, addr: 25'h0, data: 16'h0, chk_addr: 1'b0, chk_data: 1'b0});
        press(K1);
        run_cmd(2, 1'b1, 16'hA5A5, 2'b00);
        vec_cnt++;
        if (displayData !== 16'h0000 || exp_q.size() != 0) begin
            miss_cnt++;
            $display("FAIL clear_cmd_end: disp=%h pending=%0d, required 0000 0", displayData, exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_addr_entry();
        test_write_cmd();
        test_read_cmd();
        test_digits();
        test_timeout();
        test_abort_and_reset();
        test_clear_cmd();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
